// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the unified-memory arbiter.
//   state_t : arbiter FSM states
//   owner_t : which requester owns the in-flight access
//   DEF_*   : default address/data widths
//   be_width: byte-enable width for a given data width
package riscv_mem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_BE_W   = DEF_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/riscv_mem_arbiter.sv
// Arbiter sharing one single-port instruction/data memory between the IF
// stage (fetch port) and the MEM stage (load/store port).
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no access in flight; arbitrate between d_req and if_req
// ISSUE | mem_en strobed for one cycle with the latched request
// WAIT  | counting down remaining memory wait states
// ACK   | owner's ack high; read data passed through from memory
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr                fetch request (held until if_ack)
//   if_rdata/if_ack/stall_if      fetch completion and stall
//   d_req/d_we/d_addr/d_wdata/d_be  load/store request (held until d_ack)
//   d_rdata/d_ack/stall_mem       data completion and stall
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata  registered memory command
//   mem_rdata                     memory read data, WAIT_CYC after mem_en
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int WAIT_CYC   = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  output logic                stall_if,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                stall_mem,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = be_width(DATA_W);
  localparam int WCW  = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam int SCW  = $clog2(STARVE_LIM + 1);

  localparam logic [WCW-1:0] WAIT_LOAD = WCW'(WAIT_CYC - 1);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIM);

  state_t         state;
  owner_t         owner;
  logic [WCW-1:0] wait_cnt;
  logic [SCW-1:0] starve_cnt;
  logic           grant_d;

  // Data wins unless fetch has been passed over STARVE_LIM times in a row.
  assign grant_d = d_req && !(if_req && (starve_cnt == STARVE_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_I;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            owner     <= OWN_D;
            mem_addr  <= d_addr;
            mem_we    <= d_we;
            mem_be    <= d_we ? d_be : {BE_W{1'b1}};
            mem_wdata <= d_wdata;
            mem_en    <= 1'b1;
            state     <= ISSUE;
            if (!if_req)
              starve_cnt <= '0;
            else if (starve_cnt != STARVE_MAX)
              starve_cnt <= starve_cnt + SCW'(1);
          end else if (if_req) begin
            owner      <= OWN_I;
            mem_addr   <= if_addr;
            mem_we     <= 1'b0;
            mem_be     <= {BE_W{1'b1}};
            mem_wdata  <= '0;
            mem_en     <= 1'b1;
            state      <= ISSUE;
            starve_cnt <= '0;
          end
        end
        ISSUE: begin
          wait_cnt <= WAIT_LOAD;
          if (WAIT_CYC > 1) begin
            state <= WAIT;
          end else begin
            state  <= ACK;
            if_ack <= (owner == OWN_I);
            d_ack  <= (owner == OWN_D);
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - WCW'(1);
          // Leaving when the count hits zero puts ack exactly WAIT_CYC
          // cycles after the mem_en strobe.
          if (wait_cnt == WCW'(1)) begin
            state  <= ACK;
            if_ack <= (owner == OWN_I);
            d_ack  <= (owner == OWN_D);
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Read data is only meaningful in the ack cycle; stores return zero.
  assign if_rdata  = (if_ack && !mem_we) ? mem_rdata : '0;
  assign d_rdata   = (d_ack  && !mem_we) ? mem_rdata : '0;
  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = d_req & ~d_ack;

endmodule
